// File: rtl/bus_mem_slave_if.sv
// Request/response bundle between a bus master and the generic memory slave.
interface bus_mem_slave_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int ERRCNT_W = 8
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] strb;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   rdata;
    logic                ready;
    logic                error;
    logic [ERRCNT_W-1:0] err_count;

    modport master (
        output address, wdata, strb, read, write,
        input  rdata, ready, error, err_count
    );

    modport slave (
        input  address, wdata, strb, read, write,
        output rdata, ready, error, err_count
    );
endinterface

// File: rtl/bus_mem_slave.sv
// Generic synchronous memory slave: captures a request in IDLE, optionally
// waits WAIT_STATES cycles, performs the access on RESP entry and pulses ready
// for one cycle. Errors (read+write together, or address beyond DEPTH) return
// rdata=0 / error=1 and bump a saturating error counter.
module bus_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int ERRCNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_mem_slave_if.slave  bus
);
    localparam int                STRB_W  = DATA_W / 8;
    localparam logic [3:0]        WAIT_LD = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERRCNT_W-1:0] CNT_MAX = {ERRCNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          wait_cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   strb_r;
    logic                rd_r;
    logic                wr_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                ready_r;
    logic                error_r;
    logic [ERRCNT_W-1:0] err_count_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                req_s;
    logic                enter_resp_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_wdata_s;
    logic [STRB_W-1:0]   acc_strb_s;
    logic                acc_rd_s;
    logic                acc_wr_s;
    logic                in_range_s;
    logic                acc_err_s;
    logic                mem_we_s;
    logic [DATA_W-1:0]   rd_word_s;

    // Decide whether this edge enters RESP and which request values it uses;
    // with zero wait states the live inputs are captured and accessed at once.
    always_comb begin
        req_s        = bus.read | bus.write;
        enter_resp_s = 1'b0;
        case (state_r)
            S_IDLE:  enter_resp_s = req_s && (WAIT_LD == 4'd0);
            S_WAIT:  enter_resp_s = (wait_cnt_r == 4'd1);
            default: enter_resp_s = 1'b0;
        endcase

        if (state_r == S_IDLE) begin
            acc_addr_s  = bus.address;
            acc_wdata_s = bus.wdata;
            acc_strb_s  = bus.strb;
            acc_rd_s    = bus.read;
            acc_wr_s    = bus.write;
        end else begin
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_strb_s  = strb_r;
            acc_rd_s    = rd_r;
            acc_wr_s    = wr_r;
        end

        in_range_s = ({1'b0, acc_addr_s} < DEPTH_V);
        acc_err_s  = (acc_rd_s & acc_wr_s) | ~in_range_s;
        mem_we_s   = enter_resp_s & acc_wr_s & ~acc_err_s;

        if (in_range_s) begin
            rd_word_s = mem_r[acc_addr_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Byte-masked memory write on RESP entry; an edge coincident with reset
    // must not commit, so the write is qualified by rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s && rst_n) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (acc_strb_s[b]) begin
                    mem_r[acc_addr_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered response outputs and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            wait_cnt_r  <= 4'd0;
            addr_r      <= '0;
            wdata_r     <= '0;
            strb_r      <= '0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            rdata_r     <= '0;
            ready_r     <= 1'b0;
            error_r     <= 1'b0;
            err_count_r <= '0;
        end else begin
            if (enter_resp_s) begin
                ready_r <= 1'b1;
                error_r <= acc_err_s;
                if (acc_rd_s && !acc_err_s) begin
                    rdata_r <= rd_word_s;
                end else begin
                    rdata_r <= '0;
                end
                if (acc_err_s && (err_count_r != CNT_MAX)) begin
                    err_count_r <= err_count_r + {{(ERRCNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                ready_r <= 1'b0;
                error_r <= 1'b0;
                rdata_r <= '0;
            end

            case (state_r)
                S_IDLE: begin
                    if (req_s) begin
                        addr_r     <= bus.address;
                        wdata_r    <= bus.wdata;
                        strb_r     <= bus.strb;
                        rd_r       <= bus.read;
                        wr_r       <= bus.write;
                        wait_cnt_r <= WAIT_LD;
                        if (WAIT_LD == 4'd0) begin
                            state_r <= S_RESP;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 4'd1;
                    if (wait_cnt_r == 4'd1) begin
                        state_r <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata     = rdata_r;
    assign bus.ready     = ready_r;
    assign bus.error     = error_r;
    assign bus.err_count = err_count_r;
endmodule
